// File: rtl/peripheral_seqalu.sv
// Multi-cycle unsigned ALU: add/sub take one CALC cycle, while mul (shift-add)
// and div (restoring) retire one bit per clock over WIDTH iterations.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; operands latched on acceptance
// ST_CALC | add/sub/div-by-zero single pass, or mul/div iteration
// ST_DONE | result and flags registered, done pulse, back to idle
module peripheral_seqalu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [1:0]       opcode,
    input  logic             start,
    output logic [WIDTH-1:0] dataR,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             divzero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;

    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic               r_divzero;
    logic               r_done;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic               w_last;
    logic               w_b_zero;
    logic               w_finish;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_divzero;

    always_comb begin
        w_sum     = {1'b0, r_a} + {1'b0, r_b};
        w_diff    = {1'b0, r_a} - {1'b0, r_b};
        w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        // Restoring step: a negative trial (borrow in the top bit) keeps the shifted remainder.
        w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_b};
        w_qbit    = ~w_trial[WIDTH];
        w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
        w_last    = (r_cnt == CNT_W'(WIDTH - 1));
        w_b_zero  = (r_b == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                case (r_op)
                    OP_ADD, OP_SUB: w_finish = 1'b1;
                    OP_MUL:         w_finish = w_last;
                    default:        w_finish = w_b_zero | w_last;
                endcase
                if (w_finish) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_divzero = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_MUL: begin
                w_res   = w_acc_nxt[WIDTH-1:0];
                w_carry = |w_acc_nxt[2*WIDTH-1:WIDTH];
            end
            default: begin
                if (w_b_zero) begin
                    w_res     = '1;
                    w_divzero = 1'b1;
                end else begin
                    w_res = w_quo_nxt;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_ADD;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_divzero <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= dataA;
                        r_b      <= dataB;
                        r_op     <= opcode;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, dataA};
                        r_mplier <= dataB;
                        r_dvd    <= dataA;
                        r_rem    <= '0;
                        r_quo    <= '0;
                    end
                end
                ST_CALC: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_dvd    <= r_dvd << 1;
                    r_rem    <= w_rem_nxt;
                    r_quo    <= w_quo_nxt;
                end
                default: ;
            endcase

            r_done <= w_finish;
            if (w_finish) begin
                r_res     <= w_res;
                r_carry   <= w_carry;
                r_divzero <= w_divzero;
            end
        end
    end

    assign dataR   = r_res;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign carry   = r_carry;
    assign divzero = r_divzero;

endmodule

// File: tb/tb_peripheral_seqalu.sv
// Scoreboard bench for peripheral_seqalu: stimulus pushes model results with
// their due cycle, a negedge monitor pops and compares on every done pulse.
module tb_peripheral_seqalu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [1:0]  opcode;
    logic        start;
    logic [31:0] dataR;
    logic        busy;
    logic        done;
    logic        carry;
    logic        divzero;

    peripheral_seqalu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .opcode  (opcode),
        .start   (start),
        .dataR   (dataR),
        .busy    (busy),
        .done    (done),
        .carry   (carry),
        .divzero (divzero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        dz;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] hold_res = 32'h0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        exp_t e;
        longint unsigned p;
        e.dz = 1'b0;
        e.c  = 1'b0;
        e.due = 0;
        case (op)
            2'b00: begin
                p = longint'(a) + longint'(b);
                e.res = p[31:0];
                e.c   = (p >= 64'h1_0000_0000);
            end
            2'b01: begin
                e.res = a - b;
                e.c   = (a < b);
            end
            2'b10: begin
                p = longint'(a) * longint'(b);
                e.res = p[31:0];
                e.c   = ((p >> 32) != 0);
            end
            default: begin
                if (b == 0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.dz  = 1'b1;
                end else begin
                    e.res = a / b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100; k++) begin
            if (busy == 1'b0) break;
            tick(1);
        end
        if (k == 100) chk("wait_idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    // Returns after the acceptance edge; the done pulse is due WIDTH or 1 edges later.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        exp_t e;
        wait_idle();
        dataA  = a;
        dataB  = b;
        opcode = op;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        e = model(a, b, op);
        e.due = cyc + (((op == 2'b10) || (op == 2'b11 && b != 0)) ? 32 : 1);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            hold_res  = 32'h0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_single_cycle", {31'b0, prev_done}, 32'h0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("dataR", dataR, e.res);
                    chk("carry", {31'b0, carry}, {31'b0, e.c});
                    chk("divzero", {31'b0, divzero}, {31'b0, e.dz});
                    chk("done_cycle", cyc, e.due);
                    hold_res = e.res;
                end
            end else begin
                chk("dataR_hold", dataR, hold_res);
            end
            prev_done = done;
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int k;

        reset  = 1'b0;
        start  = 1'b0;
        dataA  = 32'h0;
        dataB  = 32'h0;
        opcode = 2'b00;
        tick(3);
        chk("rst_dataR", dataR, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_carry", {31'b0, carry}, 32'h0);
        chk("rst_divzero", {31'b0, divzero}, 32'h0);
        reset = 1'b1;
        tick(1);

        issue(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        issue(32'h0000_0005, 32'h0000_0007, 2'b01);
        issue(32'h0000_0007, 32'h0000_0005, 2'b01);
        issue(32'h0001_0000, 32'h0001_0001, 2'b10);
        issue(32'd1234, 32'd5678, 2'b10);
        issue(32'd100, 32'd7, 2'b11);
        issue(32'hDEAD_BEEF, 32'h0, 2'b11);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
        issue(32'h8000_0000, 32'h1, 2'b11);
        issue(32'h0, 32'h0, 2'b01);

        // Starts during busy (including the done cycle) and late operand changes must be ignored.
        issue(32'h0001_2345, 32'h0000_0ABC, 2'b10);
        tick(2);
        dataA = 32'hCAFE_F00D;
        tick(2);
        opcode = 2'b00;
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        tick(27);
        start  = 1'b1;
        tick(1);
        start  = 1'b0;
        chk("busy_after_done", {31'b0, busy}, 32'h0);
        tick(1);
        chk("start_in_done_ignored", {31'b0, busy}, 32'h0);

        // Reset in the middle of a division aborts it.
        issue(32'h1234_5678, 32'd3, 2'b11);
        tick(9);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_dataR", dataR, 32'h0);
        chk("abort_carry", {31'b0, carry}, 32'h0);
        chk("abort_divzero", {31'b0, divzero}, 32'h0);
        q.delete();
        tick(2);
        reset = 1'b1;
        tick(1);
        issue(32'h8000_0001, 32'h8000_0002, 2'b00);

        for (k = 0; k < 30; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 255));
                2: a = 32'($urandom_range(0, 65535));
                default: ;
            endcase
            issue(a, b, op);
        end

        for (k = 0; k < 100; k++) begin
            if (q.size() == 0) break;
            tick(1);
        end
        chk("scoreboard_drained", q.size(), 32'h0);
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_seqalu.md
# peripheral_seqalu

Multi-cycle 32-bit arithmetic unit sitting directly downstream of the operand-entry peripheral: it consumes the assembled 32-bit operands A and B, executes one operation per `start` pulse, and returns the 32-bit result that the entry peripheral reads back byte-by-byte onto the display path as `dataR`. Add/subtract complete in fixed short latency; multiply and divide are iterative (shift-add / restoring), one bit per clock.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

- `clk`  input  1  single system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `dataA`  input  WIDTH  operand A, unsigned.
- `dataB`  input  WIDTH  operand B, unsigned.
- `opcode`  input  2  00 add, 01 sub, 10 mul, 11 div.
- `start`  input  1  request; sampled only in IDLE.
- `dataR`  output  WIDTH  result register; holds until the next completion.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle pulse when `dataR` and the flags update.
- `carry`  output  1  add: carry-out; sub: borrow (A<B); mul: upper WIDTH product bits non-zero; div: 0.
- `divzero`  output  1  div with B=0; else 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if `start`=1, latch `dataA`, `dataB`, `opcode` into internal registers, clear the iteration counter, go to CALC. Otherwise stay.
- CALC, add/sub: compute on the latched operands in WIDTH+1 bits, then go to DONE.
- CALC, div with latched B=0: no iteration; result is all ones, `divzero`=1, then go to DONE.
- CALC, mul: shift-add over WIDTH iterations. Each cycle, if multiplier LSB=1, add the multiplicand into a 2·WIDTH accumulator. Then shift the multiplier right and the multiplicand left. After iteration WIDTH-1, go to DONE. The result is the low WIDTH bits; `carry` is the OR of the high WIDTH bits.
- CALC, div: restoring division over WIDTH iterations, MSB first. Shift the remainder left and bring in the next dividend bit. Trial-subtract B; if the result is non-negative, keep it and set the quotient bit to 1. The result is the quotient; the remainder is discarded.
- DONE: `dataR`, `carry`, and `divzero` are registered on entry to this state. `done`=1 for this single cycle, then go to IDLE.
- Arithmetic is modulo 2^WIDTH; all operands are unsigned.
- `start` while `busy`=1 is ignored, with no queuing; this includes the DONE cycle.
- Input changes after acceptance have no effect, because the operands were latched.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values and the state returns to IDLE.

## Timing
- Reset values: `dataR`=0, `busy`=0, `done`=0, `carry`=0, `divzero`=0, state IDLE, counter 0.
- Cycle 0 is the edge at which `start` is sampled in IDLE. `busy` rises after that edge.
- Add, sub, and div-by-zero: CALC occupies cycle 1; `done` and the new `dataR` are visible in cycle 2. Latency is 2.
- Mul and div: CALC occupies cycles 1..WIDTH; `done` and the new `dataR` are visible in cycle WIDTH+1 (33 by default).
- `busy` falls in the cycle after `done`. The earliest next accepted `start` is that cycle.
- Throughput: one operation every 3 cycles for add/sub, and every WIDTH+2 cycles for mul/div.
- `done` is never high for more than one consecutive cycle.
- The flags update only together with `done`.

## Test plan
- Add: A=0xFFFFFFFF, B=0x00000001, op 00, start pulse -> `done` in cycle 2, `dataR`=0x00000000, `carry`=1, `divzero`=0.
- Sub: A=0x00000005, B=0x00000007, op 01 -> `dataR`=0xFFFFFFFE, `carry`=1. Then A=7, B=5 -> `dataR`=2, `carry`=0.
- Mul: A=0x00010000, B=0x00010001, op 10 -> `done` exactly in cycle 33, `dataR`=0x00010000, `carry`=1. A=1234, B=5678 -> `dataR`=7006652, `carry`=0.
- Div: A=100, B=7, op 11 -> `dataR`=14 in cycle 33. A=0xDEADBEEF, B=0 -> `dataR`=0xFFFFFFFF, `divzero`=1, `done` in cycle 2.
- Busy rules: start a mul, pulse `start` with op 00 at cycles 5 and 33 and change `dataA` at cycle 3 -> a single `done` at cycle 33 with the original mul result; `busy` is low at cycle 34.
- Reset: drop `reset` at cycle 10 of a div -> `busy`, `done`, `dataR`, and the flags are 0 immediately. After release, a new add completes normally with latency 2.
